// File: rtl/mesi_isc_broad_pkg.sv
// Shared command/type codes and controller state encoding for the MESI broadcast controller.
// Pure definitions: no latency, no flow control.
package mesi_isc_broad_pkg;

  localparam logic [2:0] CMD_NOP      = 3'd0;
  localparam logic [2:0] CMD_WR_SNOOP = 3'd1;
  localparam logic [2:0] CMD_RD_SNOOP = 3'd2;
  localparam logic [2:0] CMD_EN_WR    = 3'd3;
  localparam logic [2:0] CMD_EN_RD    = 3'd4;

  localparam logic [1:0] TYPE_RD = 2'd1;
  localparam logic [1:0] TYPE_WR = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SNOOP,
    ST_GRANT,
    ST_POP
  } state_t;

  function automatic logic [2:0] snoop_cmd(input logic [1:0] kind);
    return (kind == TYPE_WR) ? CMD_WR_SNOOP : CMD_RD_SNOOP;
  endfunction

  function automatic logic [2:0] grant_cmd(input logic [1:0] kind);
    return (kind == TYPE_WR) ? CMD_EN_WR : CMD_EN_RD;
  endfunction

endpackage

// File: rtl/mesi_isc_basic_fifo.sv
// Generic show-ahead FIFO; head visible the cycle after the first push.
// Push while full is dropped unless a pop happens in the same cycle.
module mesi_isc_basic_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  do_wr;
  logic                  do_rd;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_rd   = rd && !empty;
  assign do_wr   = wr && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mesi_isc_broad_mc.sv
// Broadcast snoop controller: queued requests are snooped to all other CPUs, then granted to the initiator; commands are registered.
// Waits on acks indefinitely unless MESI_ISC_BROAD_TIMEOUT_EN enables the sticky watchdog that forces the pop.
module mesi_isc_broad_mc
  import mesi_isc_broad_pkg::*;
#(
  parameter int CPU_COUNT      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int BROAD_ID_WIDTH = 5,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         broad_fifo_wr_i,
  input  logic [ADDR_WIDTH-1:0]        broad_addr_i,
  input  logic [1:0]                   broad_type_i,
  input  logic [$clog2(CPU_COUNT)-1:0] broad_cpu_id_i,
  input  logic [BROAD_ID_WIDTH-1:0]    broad_id_i,
  input  logic [CPU_COUNT-1:0]         cbus_ack_array_i,
  output logic [ADDR_WIDTH-1:0]        cbus_addr_o,
  output logic [CPU_COUNT*3-1:0]       cbus_cmd_array_o,
  output logic [BROAD_ID_WIDTH-1:0]    broad_id_o,
  output logic                         fifo_status_full_o,
  output logic                         fifo_status_empty_o,
  output logic                         busy_o,
  output logic                         timeout_o
);

  localparam int CW = $clog2(CPU_COUNT);
  localparam int DW = ADDR_WIDTH + 2 + CW + BROAD_ID_WIDTH;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     addr;
    logic [1:0]                kind;
    logic [CW-1:0]             cpu;
    logic [BROAD_ID_WIDTH-1:0] id;
  } req_t;

  req_t                   push_req;
  req_t                   head_req;
  req_t                   req_q;
  req_t                   req_d;
  logic                   valid_q;
  logic                   valid_d;
  state_t                 state_q;
  state_t                 state_d;
  logic [CPU_COUNT-1:0]   pending_q;
  logic [CPU_COUNT-1:0]   pending_d;
  logic [CPU_COUNT*3-1:0] cmd_q;
  logic [CPU_COUNT*3-1:0] cmd_d;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   tmo_hit;

  function automatic logic req_ok(input req_t r);
    return ((r.kind == TYPE_RD) || (r.kind == TYPE_WR)) && (int'(r.cpu) < CPU_COUNT);
  endfunction

  assign push_req = '{addr: broad_addr_i, kind: broad_type_i, cpu: broad_cpu_id_i, id: broad_id_i};

  mesi_isc_basic_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (broad_fifo_wr_i),
    .wr_data (push_req),
    .rd      (state_q == ST_POP),
    .rd_data (head_req),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef MESI_ISC_BROAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_flag;

  // Hit on the TIMEOUT_CYCLES-th consecutive cycle spent waiting for acks.
  assign tmo_hit   = ((state_q == ST_SNOOP) || (state_q == ST_GRANT)) &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_o = tmo_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if ((state_q == ST_SNOOP) || (state_q == ST_GRANT)) tmo_cnt <= tmo_cnt + 1'b1;
      else tmo_cnt <= '0;
      if (tmo_hit) tmo_flag <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    valid_d   = valid_q;
    pending_d = '0;
    cmd_d     = '0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_SNOOP;
          req_d   = head_req;
          valid_d = req_ok(head_req);
        end
      end
      ST_SNOOP: begin
        if (!valid_q) state_d = ST_POP;
        else if ((pending_q & ~cbus_ack_array_i) == '0) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (cbus_ack_array_i[req_q.cpu]) state_d = ST_POP;
      end
      ST_POP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (tmo_hit) state_d = ST_POP;

    // pending mirrors which snoop commands are live, so it also masks the acks.
    for (int n = 0; n < CPU_COUNT; n++) begin
      if (state_d == ST_SNOOP) begin
        if (state_q == ST_IDLE) pending_d[n] = valid_d && (n != int'(req_d.cpu));
        else pending_d[n] = pending_q[n] && !cbus_ack_array_i[n];
        if (pending_d[n]) cmd_d[3*n +: 3] = snoop_cmd(req_d.kind);
      end else if ((state_d == ST_GRANT) && (n == int'(req_d.cpu))) begin
        cmd_d[3*n +: 3] = grant_cmd(req_d.kind);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      valid_q   <= 1'b0;
      pending_q <= '0;
      cmd_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      cmd_q     <= cmd_d;
    end
  end

  assign cbus_cmd_array_o    = cmd_q;
  assign cbus_addr_o         = req_q.addr;
  assign broad_id_o          = req_q.id;
  assign busy_o              = (state_q != ST_IDLE);
  assign fifo_status_full_o  = fifo_full;
  assign fifo_status_empty_o = fifo_empty;

endmodule

// File: tb/tb_mesi_isc_broad_mc.sv
// Directed bench for mesi_isc_broad_mc: a 4-CPU instance driven from a vector table plus
// hand sequences, and an 8-CPU instance (TIMEOUT_CYCLES=10) for wide command fields and the watchdog.
module tb_mesi_isc_broad_mc;
  import mesi_isc_broad_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        wr4 = 0;
  logic [31:0] addr4 = 0;
  logic [1:0]  type4 = 0;
  logic [1:0]  cpu4 = 0;
  logic [4:0]  id4 = 0;
  logic [3:0]  ack4 = 0;
  logic [31:0] caddr4;
  logic [11:0] cmd4;
  logic [4:0]  ido4;
  logic        full4, empty4, busy4, tmo4;

  logic        wr8 = 0;
  logic [31:0] addr8 = 0;
  logic [1:0]  type8 = 0;
  logic [2:0]  cpu8 = 0;
  logic [4:0]  id8 = 0;
  logic [7:0]  ack8 = 0;
  logic [31:0] caddr8;
  logic [23:0] cmd8;
  logic [4:0]  ido8;
  logic        full8, empty8, busy8, tmo8;

  mesi_isc_broad_mc #(.CPU_COUNT(4)) u4 (
    .clk(clk), .rst(rst), .broad_fifo_wr_i(wr4), .broad_addr_i(addr4),
    .broad_type_i(type4), .broad_cpu_id_i(cpu4), .broad_id_i(id4),
    .cbus_ack_array_i(ack4), .cbus_addr_o(caddr4), .cbus_cmd_array_o(cmd4),
    .broad_id_o(ido4), .fifo_status_full_o(full4), .fifo_status_empty_o(empty4),
    .busy_o(busy4), .timeout_o(tmo4)
  );

  mesi_isc_broad_mc #(.CPU_COUNT(8), .TIMEOUT_CYCLES(10)) u8 (
    .clk(clk), .rst(rst), .broad_fifo_wr_i(wr8), .broad_addr_i(addr8),
    .broad_type_i(type8), .broad_cpu_id_i(cpu8), .broad_id_i(id8),
    .cbus_ack_array_i(ack8), .cbus_addr_o(caddr8), .cbus_cmd_array_o(cmd8),
    .broad_id_o(ido8), .fifo_status_full_o(full8), .fifo_status_empty_o(empty8),
    .busy_o(busy8), .timeout_o(tmo8)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  kind;
    logic [1:0]  cpu;
    logic [4:0]  id;
    logic [3:0]  ack;
    logic [11:0] cmd;
    logic        busy;
    logic        empty;
    logic        full;
    logic [31:0] addr_o;
    logic [4:0]  id_o;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [1:0] k,
                              input logic [1:0] c, input logic [4:0] i, input logic [3:0] ack,
                              input logic [11:0] cmd, input logic busy, input logic empty,
                              input logic full, input logic [31:0] ao, input logic [4:0] io);
    vec_t v;
    v.wr = w; v.addr = a; v.kind = k; v.cpu = c; v.id = i; v.ack = ack;
    v.cmd = cmd; v.busy = busy; v.empty = empty; v.full = full; v.addr_o = ao; v.id_o = io;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic w, input logic [31:0] a, input logic [1:0] k,
                        input logic [1:0] c, input logic [4:0] i, input logic [3:0] ack);
    wr4 = w; addr4 = a; type4 = k; cpu4 = c; id4 = i; ack4 = ack;
    tick();
    wr4 = 0; ack4 = 0;
  endtask

  task automatic drive8(input logic w, input logic [31:0] a, input logic [1:0] k,
                        input logic [2:0] c, input logic [4:0] i, input logic [7:0] ack);
    wr8 = w; addr8 = a; type8 = k; cpu8 = c; id8 = i; ack8 = ack;
    tick();
    wr8 = 0; ack8 = 0;
  endtask

  task automatic expect4(input string tag, input logic [11:0] cmd, input logic busy,
                         input logic empty, input logic full);
    check({tag, " cmd"}, cmd4, cmd);
    check({tag, " busy"}, busy4, busy);
    check({tag, " empty"}, empty4, empty);
    check({tag, " full"}, full4, full);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [23:0] exp8;
    logic [4:0]  drain_ids [4];

    // Reset state on both instances.
    rst = 1;
    tick();
    tick();
    expect4("reset4", 12'h000, 0, 1, 0);
    check("reset4 addr", caddr4, 32'h0);
    check("reset4 id", ido4, 5'd0);
    check("reset4 timeout", tmo4, 1'b0);
    check("reset8 cmd", cmd8, 24'h0);
    check("reset8 empty", empty8, 1'b1);
    check("reset8 timeout", tmo8, 1'b0);
    rst = 0;

    // Single WR from CPU1, then staggered RD from CPU2, then five pushes with no acks.
    vt.push_back(mk(1, 32'h1000, TYPE_WR, 1, 3, 4'b0000, 12'h000, 0, 0, 0, 32'h0,    0));
    vt.push_back(mk(0, 32'h0,    2'd0,    0, 0, 4'b0000, 12'h241, 1, 0, 0, 32'h1000, 3));
    vt.push_back(mk(0, 32'h0,    2'd0,    0, 0, 4'b1101, 12'h018, 1, 0, 0, 32'h1000, 3));
    vt.push_back(mk(0, 32'h0,    2'd0,    0, 0, 4'b0010, 12'h000, 1, 0, 0, 32'h1000, 3));
    vt.push_back(mk(0, 32'h0,    2'd0,    0, 0, 4'b0000, 12'h000, 0, 1, 0, 32'h1000, 3));
    vt.push_back(mk(0, 32'h0,    2'd0,    0, 0, 4'b1111, 12'h000, 0, 1, 0, 32'h1000, 3));
    vt.push_back(mk(1, 32'h2040, TYPE_RD, 2, 7, 4'b0000, 12'h000, 0, 0, 0, 32'h1000, 3));
    vt.push_back(mk(0, 32'h0,    2'd0,    0, 0, 4'b0000, 12'h412, 1, 0, 0, 32'h2040, 7));
    vt.push_back(mk(0, 32'h0,    2'd0,    0, 0, 4'b0011, 12'h400, 1, 0, 0, 32'h2040, 7));
    vt.push_back(mk(0, 32'h0,    2'd0,    0, 0, 4'b0100, 12'h400, 1, 0, 0, 32'h2040, 7));
    vt.push_back(mk(0, 32'h0,    2'd0,    0, 0, 4'b0000, 12'h400, 1, 0, 0, 32'h2040, 7));
    vt.push_back(mk(0, 32'h0,    2'd0,    0, 0, 4'b0000, 12'h400, 1, 0, 0, 32'h2040, 7));
    vt.push_back(mk(0, 32'h0,    2'd0,    0, 0, 4'b0000, 12'h400, 1, 0, 0, 32'h2040, 7));
    vt.push_back(mk(0, 32'h0,    2'd0,    0, 0, 4'b1000, 12'h100, 1, 0, 0, 32'h2040, 7));
    vt.push_back(mk(0, 32'h0,    2'd0,    0, 0, 4'b1011, 12'h100, 1, 0, 0, 32'h2040, 7));
    vt.push_back(mk(0, 32'h0,    2'd0,    0, 0, 4'b0100, 12'h000, 1, 0, 0, 32'h2040, 7));
    vt.push_back(mk(0, 32'h0,    2'd0,    0, 0, 4'b0000, 12'h000, 0, 1, 0, 32'h2040, 7));
    vt.push_back(mk(1, 32'h100,  TYPE_WR, 0, 1, 4'b0000, 12'h000, 0, 0, 0, 32'h2040, 7));
    vt.push_back(mk(1, 32'h200,  TYPE_WR, 0, 2, 4'b0000, 12'h248, 1, 0, 0, 32'h100,  1));
    vt.push_back(mk(1, 32'h300,  TYPE_WR, 0, 3, 4'b0000, 12'h248, 1, 0, 0, 32'h100,  1));
    vt.push_back(mk(1, 32'h400,  TYPE_WR, 0, 4, 4'b0000, 12'h248, 1, 0, 1, 32'h100,  1));
    vt.push_back(mk(1, 32'h500,  TYPE_WR, 0, 5, 4'b0000, 12'h248, 1, 0, 1, 32'h100,  1));
    vt.push_back(mk(0, 32'h0,    2'd0,    0, 0, 4'b1110, 12'h003, 1, 0, 1, 32'h100,  1));
    vt.push_back(mk(0, 32'h0,    2'd0,    0, 0, 4'b0001, 12'h000, 1, 0, 1, 32'h100,  1));
    vt.push_back(mk(1, 32'h600,  TYPE_WR, 0, 6, 4'b0000, 12'h000, 0, 0, 1, 32'h100,  1));

    for (int i = 0; i < vt.size(); i++) begin
      drive4(vt[i].wr, vt[i].addr, vt[i].kind, vt[i].cpu, vt[i].id, vt[i].ack);
      expect4($sformatf("row%0d", i), vt[i].cmd, vt[i].busy, vt[i].empty, vt[i].full);
      check($sformatf("row%0d addr", i), caddr4, vt[i].addr_o);
      check($sformatf("row%0d id", i), ido4, vt[i].id_o);
    end

    // Drain: the fifth push (ID 5) was dropped, the push during POP (ID 6) was kept.
    drain_ids[0] = 5'd2; drain_ids[1] = 5'd3; drain_ids[2] = 5'd4; drain_ids[3] = 5'd6;
    for (int i = 0; i < 4; i++) begin
      drive4(0, 0, 0, 0, 0, 4'b0000);
      check($sformatf("drain%0d snoop cmd", i), cmd4, 12'h248);
      check($sformatf("drain%0d id", i), ido4, drain_ids[i]);
      check($sformatf("drain%0d addr", i), caddr4, {19'd0, drain_ids[i], 8'h00});
      drive4(0, 0, 0, 0, 0, 4'b1110);
      check($sformatf("drain%0d grant cmd", i), cmd4, 12'h003);
      drive4(0, 0, 0, 0, 0, 4'b0001);
      check($sformatf("drain%0d pop busy", i), busy4, 1'b1);
      drive4(0, 0, 0, 0, 0, 4'b0000);
      check($sformatf("drain%0d idle busy", i), busy4, 1'b0);
    end
    check("drain empty", empty4, 1'b1);

    // Unknown request type is popped without any command.
    drive4(1, 32'h700, 2'd0, 1, 8, 4'b0000);
    drive4(0, 0, 0, 0, 0, 4'b0000);
    expect4("badtype snoop", 12'h000, 1, 0, 0);
    check("badtype addr", caddr4, 32'h700);
    drive4(0, 0, 0, 0, 0, 4'b1111);
    expect4("badtype pop", 12'h000, 1, 0, 0);
    drive4(0, 0, 0, 0, 0, 4'b0000);
    expect4("badtype idle", 12'h000, 0, 1, 0);

    // Reset while in GRANT with a second request queued.
    drive4(1, 32'h3000, TYPE_WR, 0, 9, 4'b0000);
    drive4(1, 32'h3100, TYPE_RD, 1, 10, 4'b0000);
    check("rstgrant snoop cmd", cmd4, 12'h248);
    drive4(0, 0, 0, 0, 0, 4'b1110);
    check("rstgrant grant cmd", cmd4, 12'h003);
    rst = 1;
    drive4(0, 0, 0, 0, 0, 4'b0000);
    rst = 0;
    expect4("rstgrant after", 12'h000, 0, 1, 0);
    drive4(0, 0, 0, 0, 0, 4'b1111);
    expect4("rstgrant idle", 12'h000, 0, 1, 0);

    // 8 CPUs, RD from CPU7: seven RD_SNOOP fields then EN_RD in [23:21].
    drive8(1, 32'hABCD0000, TYPE_RD, 7, 31, 8'h00);
    check("cpu8 push busy", busy8, 1'b0);
    drive8(0, 0, 0, 0, 0, 8'h00);
    exp8 = '0;
    for (int n = 0; n < 7; n++) exp8[3*n +: 3] = CMD_RD_SNOOP;
    check("cpu8 snoop cmd", cmd8, exp8);
    check("cpu8 addr", caddr8, 32'hABCD0000);
    drive8(0, 0, 0, 0, 0, 8'h7F);
    check("cpu8 grant cmd", cmd8, 24'h800000);
    drive8(0, 0, 0, 0, 0, 8'h80);
    check("cpu8 pop cmd", cmd8, 24'h0);
    check("cpu8 pop busy", busy8, 1'b1);
    drive8(0, 0, 0, 0, 0, 8'h00);
    check("cpu8 idle empty", empty8, 1'b1);

    // CPU2 never acks a WR from CPU0.
    drive8(1, 32'h5000, TYPE_WR, 0, 2, 8'h00);
    drive8(0, 0, 0, 0, 0, 8'h00);
    check("stuck snoop cmd", cmd8, 24'o7777_7770 & 24'o1111_1110);
    drive8(0, 0, 0, 0, 0, 8'hFA);
    check("stuck cmd after partial ack", cmd8, 24'h000040);
    for (int k = 2; k <= 9; k++) begin
      drive8(0, 0, 0, 0, 0, 8'h00);
      check($sformatf("stuck c%0d cmd", k), cmd8, 24'h000040);
      check($sformatf("stuck c%0d timeout", k), tmo8, 1'b0);
    end
    drive8(0, 0, 0, 0, 0, 8'h00);
`ifdef MESI_ISC_BROAD_TIMEOUT_EN
    check("timeout flag", tmo8, 1'b1);
    check("timeout pop cmd", cmd8, 24'h0);
    check("timeout pop busy", busy8, 1'b1);
    drive8(0, 0, 0, 0, 0, 8'h00);
    check("timeout popped empty", empty8, 1'b1);
    check("timeout sticky", tmo8, 1'b1);
    rst = 1;
    drive8(0, 0, 0, 0, 0, 8'h00);
    rst = 0;
    check("timeout cleared", tmo8, 1'b0);
`else
    check("no timeout still snooping", cmd8, 24'h000040);
    check("no timeout flag", tmo8, 1'b0);
    drive8(0, 0, 0, 0, 0, 8'h04);
    check("late ack grant cmd", cmd8, 24'h000003);
    drive8(0, 0, 0, 0, 0, 8'h01);
    drive8(0, 0, 0, 0, 0, 8'h00);
    check("late ack empty", empty8, 1'b1);
    check("tmo4 tied low", tmo4, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
